reg_hw_bridge: RTL

- Parametrised, multi-channel bridge between the register file and the hardware datapath.
- Each channel has a write path and a read path:
  - Write path (register file to hardware): a 4-phase req/ack handshake that latches a control word into hardware.
  - Read path (hardware to register file): a one-deep status holding buffer with valid/ready handshake and sticky overflow detection.
- Sits between the generated register file and custom accelerator logic; replaces per-bit enable flags with full-width words per channel.

---
 rtl/reg_hw_bridge_if.sv | 35 +++
 rtl/reg_hw_bridge.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reg_hw_bridge_if.sv
// reg_hw_bridge_if: register-file side of the bridge, grouped per direction.
//   master: the generated register file (drives write words, consumes status).
//   slave : the bridge (acknowledges writes, presents buffered status).
interface reg_hw_bridge_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DATA_W = 32
);
    // Write path, register file -> hardware.
    logic [NUM_CH*DATA_W-1:0] reg2ip_data;
    logic [NUM_CH-1:0]        reg2ip_req;
    logic [NUM_CH-1:0]        reg2ip_ack;

    // Read path, hardware -> register file.
    logic [NUM_CH*DATA_W-1:0] ip2reg_data;
    logic [NUM_CH-1:0]        ip2reg_valid;
    logic [NUM_CH-1:0]        ip2reg_ready;

    modport master (
        output reg2ip_data,
        output reg2ip_req,
        input  reg2ip_ack,
        input  ip2reg_data,
        input  ip2reg_valid,
        output ip2reg_ready
    );

    modport slave (
        input  reg2ip_data,
        input  reg2ip_req,
        output reg2ip_ack,
        output ip2reg_data,
        output ip2reg_valid,
        input  ip2reg_ready
    );
endinterface

// File: rtl/reg_hw_bridge.sv
// reg_hw_bridge: multi-channel bridge between the register file and a hardware
// datapath. Each channel has an independent 4-phase write path (control word
// latched into hardware) and a one-deep status buffer with sticky overflow.
// Optional feature: define REG_HW_BRIDGE_WCNT_EN to get per-channel wrapping
// accepted-write counters on wr_cnt_o; otherwise wr_cnt_o is tied to zero.
module reg_hw_bridge #(
    parameter int unsigned       NUM_CH   = 3,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       CNT_W    = 8,
    parameter logic [DATA_W-1:0] CTRL_RST = '0,
    parameter logic [DATA_W-1:0] STAT_RST = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    reg_hw_bridge_if.slave           reg_if,
    output logic [NUM_CH*DATA_W-1:0] hw_ctrl_o,
    output logic [NUM_CH-1:0]        hw_ctrl_upd_o,
    input  logic [NUM_CH*DATA_W-1:0] hw_status_i,
    input  logic [NUM_CH-1:0]        hw_status_we_i,
    output logic [NUM_CH-1:0]        ovf_o,
    input  logic [NUM_CH-1:0]        ovf_clr_i,
    output logic [NUM_CH*CNT_W-1:0]  wr_cnt_o
);

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_ACK  = 1'b1
    } wr_state_e;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Per-channel views of the packed buses.
        logic [DATA_W-1:0] wr_data;
        logic              wr_req;
        logic [DATA_W-1:0] st_data;
        logic              st_we;
        logic              st_ready;
        logic              st_clr;

        assign wr_data  = reg_if.reg2ip_data[c*DATA_W +: DATA_W];
        assign wr_req   = reg_if.reg2ip_req[c];
        assign st_data  = hw_status_i[c*DATA_W +: DATA_W];
        assign st_we    = hw_status_we_i[c];
        assign st_ready = reg_if.ip2reg_ready[c];
        assign st_clr   = ovf_clr_i[c];

        // ------------------------------------------------------------------
        // Write path
        // ------------------------------------------------------------------
        wr_state_e         state_q;
        logic              ack_q;
        logic              upd_q;
        logic [DATA_W-1:0] ctrl_q;
        logic              wr_accept;

        // A write is taken only from IDLE, so a held request yields one write.
        assign wr_accept = (state_q == WR_IDLE) && wr_req;

        // Write FSM: latch the word on request, hold ack until the request drops.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= WR_IDLE;
                ack_q   <= 1'b0;
                upd_q   <= 1'b0;
                ctrl_q  <= CTRL_RST;
            end else begin
                // NOTE: sequential state uses <= so every flop samples the
                // pre-edge values; = here would create ordering-dependent logic.
                upd_q <= 1'b0;
                case (state_q)
                    WR_IDLE: begin
                        if (wr_req) begin
                            ctrl_q  <= wr_data;
                            upd_q   <= 1'b1;
                            ack_q   <= 1'b1;
                            state_q <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (!wr_req) begin
                            ack_q   <= 1'b0;
                            state_q <= WR_IDLE;
                        end
                    end
                    default: begin
                        ack_q   <= 1'b0;
                        state_q <= WR_IDLE;
                    end
                endcase
            end
        end

        assign reg_if.reg2ip_ack[c]         = ack_q;
        assign hw_ctrl_upd_o[c]             = upd_q;
        assign hw_ctrl_o[c*DATA_W +: DATA_W] = ctrl_q;

        // ------------------------------------------------------------------
        // Status path
        // ------------------------------------------------------------------
        logic [DATA_W-1:0] hold_q, hold_d;
        logic              valid_q, valid_d;
        logic              ovf_q, ovf_d;
        logic              drain;

        assign drain = valid_q && st_ready;

        // Next state of the holding register: refill may coincide with drain.
        always_comb begin
            // NOTE: every variable gets a default first so no path through the
            // block leaves it unassigned, which would infer a latch.
            hold_d  = hold_q;
            valid_d = valid_q;
            if (st_we && (!valid_q || drain)) begin
                hold_d  = st_data;
                valid_d = 1'b1;
            end else if (!st_we && drain) begin
                valid_d = 1'b0;
            end
        end

        // Sticky overflow: a post into a full, non-draining buffer; set beats clear.
        always_comb begin
            ovf_d = (ovf_q && !st_clr) || (st_we && valid_q && !drain);
        end

        // Status registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hold_q  <= STAT_RST;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                hold_q  <= hold_d;
                valid_q <= valid_d;
                ovf_q   <= ovf_d;
            end
        end

        assign reg_if.ip2reg_data[c*DATA_W +: DATA_W] = hold_q;
        assign reg_if.ip2reg_valid[c]                 = valid_q;
        assign ovf_o[c]                               = ovf_q;

        // ------------------------------------------------------------------
        // Optional accepted-write counter
        // ------------------------------------------------------------------
`ifdef REG_HW_BRIDGE_WCNT_EN
        logic [CNT_W-1:0] cnt_q;

        // Count every IDLE->ACK transition; wraps naturally at 2^CNT_W.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (wr_accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign wr_cnt_o[c*CNT_W +: CNT_W] = cnt_q;
`else
        logic unused_accept;

        assign unused_accept              = wr_accept;
        assign wr_cnt_o[c*CNT_W +: CNT_W] = '0;
`endif
    end

endmodule
